mac_sequencer: RTL and testbench
================================

# mac_sequencer

Upstream control stage for the 8-bit MAC datapath. Holds a loadable bank of filter coefficients and accepts a stream of window samples over a valid/ready handshake. For each convolution it clears the MAC accumulator, then presents one window/filter pair per accepted sample while pulsing the MAC register enable. It then captures the MAC's 12-bit result and offers it downstream over a valid/ready handshake.

## Interface
Parameters:
- FILT_LEN, 16: taps per convolution; must be ≥ 2.
- DATA_W, 8: window/filter sample width.
- RES_W, 12: MAC result width.

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin one convolution; honoured only in IDLE.
- flt_wr_en  in  1  filter bank write strobe.
- flt_wr_addr  in  $clog2(FILT_LEN)  tap index to write.
- flt_wr_data  in  DATA_W  coefficient value.
- win_valid  in  1  window sample available.
- win_data  in  DATA_W  window sample.
- win_ready  out  1  sequencer accepts a window sample this cycle.
- mac_window  out  DATA_W  to MAC window input.
- mac_filter  out  DATA_W  to MAC filter input.
- mac_reg_en  out  1  to MAC reg_en.
- mac_clean_reg  out  1  to MAC clean_reg.
- mac_result  in  RES_W  from MAC result.
- out_valid  out  1  captured result available.
- out_data  out  RES_W  captured result.
- out_ready  in  1  downstream accepts the result.
- busy  out  1  high in every state except IDLE.

## Operation
- States and transitions:
  - IDLE → CLEAR when start = 1.
  - CLEAR → ACCUM unconditionally, after one cycle.
  - ACCUM → DONE on acceptance of tap FILT_LEN-1.
  - DONE → OUT unconditionally, after one cycle.
  - OUT → IDLE on out_valid & out_ready.
- CLEAR: mac_clean_reg = 1 for exactly one cycle. tap_idx is set to 0.
- ACCUM:
  - win_ready = 1 throughout this state.
  - A sample is accepted when win_valid & win_ready.
  - mac_reg_en = win_valid, combinational.
  - mac_window = win_data, combinational.
  - mac_filter = bank[tap_idx].
  - tap_idx increments on each acceptance.
  - When win_valid = 0, the state holds, mac_reg_en = 0 and tap_idx is unchanged (stall).
- DONE: mac_result now holds the final sum. out_data ← mac_result is registered at the end of this cycle.
- OUT:
  - out_valid = 1, and out_data stays stable until the handshake completes.
  - A held-off out_ready holds OUT indefinitely.
- Outside ACCUM, win_ready, mac_reg_en, mac_window and mac_filter are all 0.
- Filter bank writes:
  - Take effect only in IDLE; writes in any other state are ignored.
  - Addresses ≥ FILT_LEN are ignored.
  - A write and a start in the same IDLE cycle: the write lands first, and the convolution uses the new value.
- start outside IDLE is ignored and is not queued.
- mac_clean_reg and mac_reg_en are never high in the same cycle.

## Timing
- Reset values:
  - State = IDLE.
  - tap_idx = 0.
  - Filter bank all 0.
  - out_data = 0.
  - All outputs 0.
- Reset mid-operation aborts immediately to IDLE. Any partial result is discarded, and out_valid drops asynchronously.
- start is sampled at edge 0. CLEAR occupies cycle 1, and the first ACCUM cycle is cycle 2.
- With win_valid held high, mac_reg_en is high for cycles 2 .. FILT_LEN+1.
- DONE is cycle FILT_LEN+2.
- out_valid rises in cycle FILT_LEN+3, which is a minimum start-to-result latency of FILT_LEN+3 cycles.
- Each stalled ACCUM cycle adds one cycle of latency.
- After the output handshake, IDLE is reached next cycle, so back-to-back starts are FILT_LEN+4 cycles apart minimum.

## Structure
- Package mac_seq_pkg:
  - state_t enum: IDLE, CLEAR, ACCUM, DONE, OUT.
  - Default width localparams for DATA_W and RES_W.
- Sub-module filter_bank:
  - FILT_LEN × DATA_W register file.
  - One synchronous write port, one combinational read port, asynchronous active-low clear.
- The top level holds the FSM, tap counter and output register.

## Test plan
- Reset, then write bank[i] = i+1 for all 16 taps; start; win_valid held high with win_data = 8'h10. Check:
  - mac_clean_reg is high in cycle 1 only.
  - mac_filter steps 1..16 while mac_reg_en is high for 16 cycles.
  - out_valid rises in cycle 19.
- Bench drives mac_result = 12'hABC during DONE → out_data = 12'hABC, held until out_ready. Hold out_ready low 5 cycles → OUT persists and out_data stays stable.
- Drop win_valid for 3 cycles after tap 4 → mac_reg_en = 0 and tap_idx stays 5 during the gap. Total latency is 22 cycles and the tap order is unchanged.
- flt_wr_en to addr 3 with data 8'hFF during ACCUM, and start pulsed during OUT → both ignored. A read of bank[3] in the next run still gives the old value.
- rst asserted mid-ACCUM at tap 7 → immediate IDLE, all outputs 0, bank cleared. A fresh run afterwards completes normally.
- Write to addr 5 with 8'h22 in the same IDLE cycle as start → mac_filter = 8'h22 at tap 5.

Source files
------------

// File: rtl/mac_seq_pkg.sv
// Shared types and default widths for the MAC sequencer and its filter bank.
package mac_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ACCUM = 3'd2,
    DONE  = 3'd3,
    OUT   = 3'd4
  } state_t;

  localparam int unsigned DEF_FILT_LEN = 16;
  localparam int unsigned DEF_DATA_W   = 8;
  localparam int unsigned DEF_RES_W    = 12;

endpackage

// File: rtl/mac_sequencer_filter_bank.sv
// Coefficient register file: one synchronous write port, one combinational read
// port, cleared to zero by the asynchronous active-low reset.
module filter_bank
  import mac_seq_pkg::*;
#(
  parameter int unsigned FILT_LEN = DEF_FILT_LEN,
  parameter int unsigned DATA_W   = DEF_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [$clog2(FILT_LEN)-1:0] wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic [$clog2(FILT_LEN)-1:0] rd_addr,
  output logic [DATA_W-1:0]           rd_data
);

  logic [DATA_W-1:0] mem_q [FILT_LEN];
  logic [DATA_W-1:0] mem_d [FILT_LEN];
  logic              wr_in_range;
  logic              rd_in_range;

  // Addresses past the last tap are possible when FILT_LEN is not a power of two.
  assign wr_in_range = (32'(wr_addr) < FILT_LEN);
  assign rd_in_range = (32'(rd_addr) < FILT_LEN);

  always_comb begin
    mem_d = mem_q;
    if (wr_en && wr_in_range) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FILT_LEN); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = rd_in_range ? mem_q[rd_addr] : '0;

endmodule

// File: rtl/mac_sequencer.sv
// Control stage for the MAC datapath: clears the accumulator, streams
// window/filter pairs per accepted sample, then hands the result downstream.
module mac_sequencer
  import mac_seq_pkg::*;
#(
  parameter int unsigned FILT_LEN = DEF_FILT_LEN,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned RES_W    = DEF_RES_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        flt_wr_en,
  input  logic [$clog2(FILT_LEN)-1:0] flt_wr_addr,
  input  logic [DATA_W-1:0]           flt_wr_data,
  input  logic                        win_valid,
  input  logic [DATA_W-1:0]           win_data,
  output logic                        win_ready,
  output logic [DATA_W-1:0]           mac_window,
  output logic [DATA_W-1:0]           mac_filter,
  output logic                        mac_reg_en,
  output logic                        mac_clean_reg,
  input  logic [RES_W-1:0]            mac_result,
  output logic                        out_valid,
  output logic [RES_W-1:0]            out_data,
  input  logic                        out_ready,
  output logic                        busy
);

  localparam int unsigned AW = $clog2(FILT_LEN);
  localparam logic [AW-1:0] LAST_TAP = AW'(FILT_LEN - 1);

  if (FILT_LEN < 2) begin : g_bad_len
    $error("mac_sequencer: FILT_LEN must be at least 2");
  end

  state_t            state_q, state_d;
  logic [AW-1:0]     tap_q, tap_d;
  logic [RES_W-1:0]  out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              clean_q, clean_d;
  logic              busy_q, busy_d;

  logic              in_accum;
  logic              accept;
  logic              bank_we;
  logic [DATA_W-1:0] bank_rd;

  assign in_accum = (state_q == ACCUM);
  assign accept   = in_accum & win_valid;
  // The bank is frozen while a convolution is in flight.
  assign bank_we  = flt_wr_en & (state_q == IDLE);

  filter_bank #(
    .FILT_LEN (FILT_LEN),
    .DATA_W   (DATA_W)
  ) u_bank (
    .clk     (clk),
    .rst_n   (rst),
    .wr_en   (bank_we),
    .wr_addr (flt_wr_addr),
    .wr_data (flt_wr_data),
    .rd_addr (tap_q),
    .rd_data (bank_rd)
  );

  always_comb begin
    state_d    = state_q;
    tap_d      = tap_q;
    out_data_d = out_data_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = CLEAR;
      end
      CLEAR: begin
        tap_d   = '0;
        state_d = ACCUM;
      end
      ACCUM: begin
        if (accept) begin
          tap_d = tap_q + 1'b1;
          if (tap_q == LAST_TAP) state_d = DONE;
        end
      end
      DONE: begin
        out_data_d = mac_result;
        state_d    = OUT;
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so they leave the flops clean.
    clean_d     = (state_d == CLEAR);
    out_valid_d = (state_d == OUT);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      tap_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      clean_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      clean_q     <= clean_d;
      busy_q      <= busy_d;
    end
  end

  assign win_ready     = in_accum;
  assign mac_reg_en    = accept;
  assign mac_window    = in_accum ? win_data : '0;
  assign mac_filter    = in_accum ? bank_rd  : '0;
  assign mac_clean_reg = clean_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Randomised self-checking bench for mac_sequencer against a phase-level
// reference model of one convolution run.
module tb_mac_sequencer;

  localparam int FL = 16;
  localparam int DW = 8;
  localparam int RW = 12;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          flt_wr_en;
  logic [AW-1:0] flt_wr_addr;
  logic [DW-1:0] flt_wr_data;
  logic          win_valid;
  logic [DW-1:0] win_data;
  logic          win_ready;
  logic [DW-1:0] mac_window;
  logic [DW-1:0] mac_filter;
  logic          mac_reg_en;
  logic          mac_clean_reg;
  logic [RW-1:0] mac_result;
  logic          out_valid;
  logic [RW-1:0] out_data;
  logic          out_ready;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] bank_m [FL];

  always #5 clk = ~clk;

  mac_sequencer #(.FILT_LEN(FL), .DATA_W(DW), .RES_W(RW)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .flt_wr_en     (flt_wr_en),
    .flt_wr_addr   (flt_wr_addr),
    .flt_wr_data   (flt_wr_data),
    .win_valid     (win_valid),
    .win_data      (win_data),
    .win_ready     (win_ready),
    .mac_window    (mac_window),
    .mac_filter    (mac_filter),
    .mac_reg_en    (mac_reg_en),
    .mac_clean_reg (mac_clean_reg),
    .mac_result    (mac_result),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .busy          (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_busy"},   32'(busy),          32'd0);
    check_val({tag, "_oval"},   32'(out_valid),     32'd0);
    check_val({tag, "_clean"},  32'(mac_clean_reg), 32'd0);
    check_val({tag, "_regen"},  32'(mac_reg_en),    32'd0);
    check_val({tag, "_wrdy"},   32'(win_ready),     32'd0);
    check_val({tag, "_window"}, 32'(mac_window),    32'd0);
    check_val({tag, "_filter"}, 32'(mac_filter),    32'd0);
  endtask

  task automatic write_tap(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    @(posedge clk); #1;
    start = 1'b0; win_valid = 1'b1; win_data = 8'($urandom); out_ready = 1'b0;
    flt_wr_en = 1'b1; flt_wr_addr = addr; flt_wr_data = data;
    bank_m[addr] = data;
    @(negedge clk);
    check_quiet("wr_idle");
  endtask

  // One convolution. Phases come from the run's own progress: cycle 1 clears,
  // ACCUM lasts until FL samples are taken, DONE is one cycle, then OUT.
  task automatic run_conv(input int wfix, input int stall_at, input int stall_len,
                          input bit rand_valid, input int ready_hold, input logic [RW-1:0] res,
                          input bit same_wr, input logic [AW-1:0] same_addr,
                          input logic [DW-1:0] same_data, input bit disturb, input int abort_tap);
    int k, stalls, stall_left, hold_left, clr_cnt, en_cnt, last_acc, first_out, ph;
    bit finished, aborted;
    k = 0; stalls = 0; stall_left = stall_len; hold_left = ready_hold;
    clr_cnt = 0; en_cnt = 0; last_acc = -1; first_out = -1; finished = 0; aborted = 0;

    @(posedge clk); #1;
    start = 1'b1; win_valid = 1'b1; win_data = 8'($urandom); out_ready = 1'b0;
    flt_wr_en = same_wr; flt_wr_addr = same_addr; flt_wr_data = same_data;
    if (same_wr) bank_m[same_addr] = same_data;
    @(negedge clk);
    check_quiet("start_cyc");

    for (int cyc = 1; cyc < 400 && !finished && !aborted; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0; flt_wr_en = 1'b0; out_ready = 1'b0;
      mac_result = ~res;
      win_valid = 1'b1;
      win_data = (wfix >= 0) ? 8'(wfix) : 8'($urandom);
      if (cyc == 1) ph = 1;
      else if (k < FL) ph = 2;
      else if (cyc == last_acc + 1) ph = 3;
      else ph = 4;

      if (ph == 2) begin
        if (rand_valid) win_valid = ($urandom_range(0, 3) != 0);
        if (k == stall_at && stall_left > 0) begin
          win_valid = 1'b0;
          stall_left--;
        end
        if (disturb && k == 1) begin
          flt_wr_en = 1'b1; flt_wr_addr = 4'd3; flt_wr_data = 8'hFF;
        end
      end else if (ph == 3) begin
        mac_result = res;
      end else if (ph == 4) begin
        if (first_out < 0) first_out = cyc;
        out_ready = (hold_left == 0);
        if (disturb) start = 1'b1;
      end

      @(negedge clk);
      if (mac_clean_reg) clr_cnt++;
      if (mac_reg_en) en_cnt++;
      check_val("clean_reg", 32'(mac_clean_reg), 32'(ph == 1));
      check_val("reg_en",    32'(mac_reg_en),    32'(ph == 2 && win_valid));
      check_val("win_ready", 32'(win_ready),     32'(ph == 2));
      check_val("window",    32'(mac_window),    (ph == 2) ? 32'(win_data) : 32'd0);
      check_val("filter",    32'(mac_filter),    (ph == 2) ? 32'(bank_m[k]) : 32'd0);
      check_val("out_valid", 32'(out_valid),     32'(ph == 4));
      check_val("busy",      32'(busy),          32'd1);
      if (ph == 4) check_val("out_data", 32'(out_data), 32'(res));

      if (ph == 2 && k == abort_tap) begin
        #2 rst = 1'b0;
        #1;
        check_quiet("abort");
        check_val("abort_out_data", 32'(out_data), 32'd0);
        for (int i = 0; i < FL; i++) bank_m[i] = '0;
        rst = 1'b1;
        win_valid = 1'b0;
        aborted = 1;
      end else if (ph == 2) begin
        if (win_valid) begin
          k++;
          if (k == FL) last_acc = cyc;
        end else begin
          stalls++;
        end
      end else if (ph == 4) begin
        if (out_ready) finished = 1;
        else hold_left--;
      end
    end

    if (!aborted) begin
      if (!finished) begin
        check_val("run_timeout", 32'd0, 32'd1);
      end else begin
        check_val("latency",    32'(first_out), 32'(FL + 3 + stalls));
        check_val("clean_cnt",  32'(clr_cnt),   32'd1);
        check_val("reg_en_cnt", 32'(en_cnt),    32'(FL));
        for (int i = 0; i < 2; i++) begin
          @(posedge clk); #1;
          start = 1'b0; out_ready = 1'b0; win_valid = 1'b1; mac_result = ~res;
          @(negedge clk);
          check_quiet("post_idle");
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; flt_wr_en = 1'b0; flt_wr_addr = '0; flt_wr_data = '0;
    win_valid = 1'b0; win_data = '0; mac_result = '0; out_ready = 1'b0;
    for (int i = 0; i < FL; i++) bank_m[i] = '0;
    #3 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    check_val("reset_out_data", 32'(out_data), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < FL; i++) write_tap(AW'(i), DW'(i + 1));

    // Held-high window stream, result held off for 5 cycles.
    run_conv(8'h10, -1, 0, 1'b0, 5, 12'hABC, 1'b0, '0, '0, 1'b0, -1);
    // Three-cycle gap after tap 4, ignored write and start while busy.
    run_conv(-1, 5, 3, 1'b0, 2, 12'($urandom), 1'b0, '0, '0, 1'b1, -1);
    // Write landing in the same cycle as start.
    run_conv(-1, -1, 0, 1'b0, 0, 12'($urandom), 1'b1, 4'd5, 8'h22, 1'b0, -1);
    // Reset mid-ACCUM, then a fresh run over the cleared bank.
    run_conv(-1, -1, 0, 1'b0, 0, 12'($urandom), 1'b0, '0, '0, 1'b0, 7);
    run_conv(-1, -1, 0, 1'b0, 1, 12'($urandom), 1'b0, '0, '0, 1'b0, -1);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < FL; i++) begin
        if ($urandom_range(0, 1) == 1) write_tap(AW'(i), 8'($urandom));
      end
      run_conv(-1, -1, 0, 1'b1, int'($urandom_range(0, 4)), 12'($urandom),
               1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom), 1'b0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
